// File: rtl/fixed_to_float_packer.sv
// rtl/fixed_to_float_packer.sv - signed fixed-point to IEEE-754 single converter
// Iterative normalizer: one left shift per enabled cycle, truncating rounding.
module fixed_to_float_packer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH+1:0] dataa,
  output logic [31:0]      result,
  output logic             done,
  output logic             busy
);

  localparam int MSB = WIDTH + 1;
  // Leading one sitting in the MSB of the magnitude weighs 2^(MSB-WIDTH).
  localparam logic [7:0] EXP_INIT = 8'(127 + MSB - WIDTH);

  typedef enum logic {IDLE, NORM} state_t;

  state_t      state, state_nx;
  logic [MSB:0] mag, mag_nx;
  logic [7:0]  exp_q, exp_nx;
  logic        sgn, sgn_nx;
  logic [31:0] result_nx;
  logic        done_nx;
  logic [MSB:0] abs_val;

  // Unsigned magnitude: the most negative input maps onto the MSB without overflow.
  assign abs_val = dataa[MSB] ? (~dataa + (MSB+1)'(1)) : dataa;

  always_comb begin
    state_nx  = state;
    mag_nx    = mag;
    exp_nx    = exp_q;
    sgn_nx    = sgn;
    result_nx = result;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sgn_nx   = dataa[MSB];
          mag_nx   = abs_val;
          exp_nx   = EXP_INIT;
          state_nx = NORM;
        end
      end
      NORM: begin
        if (mag == '0) begin
          result_nx = 32'h0000_0000;
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end else if (mag[MSB]) begin
          result_nx = {sgn, exp_q, mag[MSB-1 -: 23]};
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end else begin
          mag_nx = mag << 1;
          exp_nx = exp_q - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      mag    <= '0;
      exp_q  <= '0;
      sgn    <= 1'b0;
      result <= 32'h0000_0000;
      done   <= 1'b0;
    end else if (clk_en) begin
      state  <= state_nx;
      mag    <= mag_nx;
      exp_q  <= exp_nx;
      sgn    <= sgn_nx;
      result <= result_nx;
      done   <= done_nx;
    end
  end

  assign busy = (state == NORM);

endmodule
